// File: rtl/alu_pkg.sv
// Shared definitions for the UART command parser and the ALU it feeds:
// the operation encoding and the ASCII opcode bytes that select it.
package alu_pkg;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } operation_t;

  localparam logic [7:0] OPC_ADD = 8'h2B;  // '+'
  localparam logic [7:0] OPC_SUB = 8'h2D;  // '-'

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GET_A = 2'd1,
    ST_GET_B = 2'd2
  } parser_state_t;

  // Map an opcode byte to an operation; anything unrecognised yields NOP.
  function automatic operation_t decode_opcode(input logic [7:0] b);
    operation_t op;
    op = NOP;
    if (b == OPC_ADD) op = ADD;
    else if (b == OPC_SUB) op = SUB;
    return op;
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// UART command parser: turns a 3-byte frame (opcode, A, B) into one ALU
// command strobe. Bad opcodes raise a one-cycle err pulse.
// Optional inter-byte timeout: define UART_CMD_TIMEOUT_EN to abandon a
// partial frame after TIMEOUT_CYCLES idle cycles (err pulse, back to IDLE).
module uart_cmd_parser
  import alu_pkg::*;
#(
  parameter int WIDTH          = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  output operation_t       op_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             out_valid,
  output logic             err
);

  parser_state_t    state_q, state_d;
  operation_t       op_hold_q, op_hold_d;
  logic [WIDTH-1:0] a_hold_q, a_hold_d;
  operation_t       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic             timeout_hit;
  operation_t       rx_op;

  assign rx_op = decode_opcode(rx_data);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int CNT_W = 24;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Timeout fires only on an idle cycle inside a frame; a coinciding byte wins.
  always_comb begin
    timeout_hit = (state_q != ST_IDLE) && !rx_done && (cnt_q == CNT_LAST);
  end

  // Idle-cycle counter: cleared by every byte, by IDLE and by a timeout.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (rx_done || (state_q == ST_IDLE) || timeout_hit) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State and output registers; outputs return to their idle values on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= NOP;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Partial-frame holding registers; never visible on the outputs directly.
  always_ff @(posedge clk) begin
    op_hold_q <= op_hold_d;
    a_hold_q  <= a_hold_d;
  end

  // Next-state logic: advance one step per received byte.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_done && (rx_op != NOP)) state_d = ST_GET_A;
      end
      ST_GET_A: begin
        if (rx_done)          state_d = ST_GET_B;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_GET_B: begin
        if (rx_done)          state_d = ST_IDLE;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic: capture fields and publish a command on byte B.
  always_comb begin
    op_hold_d   = op_hold_q;
    a_hold_d    = a_hold_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_done) begin
          if (rx_op != NOP) op_hold_d = rx_op;
          else              err_d     = 1'b1;
        end
      end
      ST_GET_A: begin
        if (rx_done) a_hold_d = rx_data[WIDTH-1:0];
        else         err_d    = timeout_hit;
      end
      ST_GET_B: begin
        if (rx_done) begin
          op_d        = op_hold_q;
          a_d         = a_hold_q;
          b_d         = rx_data[WIDTH-1:0];
          out_valid_d = 1'b1;
        end else begin
          err_d = timeout_hit;
        end
      end
      default: ;
    endcase
  end

  assign op_out    = op_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frames with literal expectations plus
// randomized byte streams checked every cycle against a frame-level model.
// Honours UART_CMD_TIMEOUT_EN the same way as the design.
module tb_uart_cmd_parser;
  import alu_pkg::*;

  localparam int WIDTH   = 6;
  localparam int TIMEOUT = 16;
  localparam int MASK    = (1 << WIDTH) - 1;
`ifdef UART_CMD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_done = 1'b0;
  operation_t       op_out;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             out_valid;
  logic             err;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  uart_cmd_parser #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .op_out(op_out), .a_out(a_out), .b_out(b_out),
    .out_valid(out_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Frame-level reference model: a list of bytes collected so far and an
  // idle-cycle count; expectations describe the outputs after this edge.
  int   frame_len = 0;
  int   frame_op  = 0;
  int   frame_a   = 0;
  int   idle_cnt  = 0;
  int   exp_op    = 0;
  int   exp_a     = 0;
  int   exp_b     = 0;
  bit   exp_valid = 1'b0;
  bit   exp_err   = 1'b0;

  always @(posedge clk) begin
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (rst) begin
      frame_len = 0; idle_cnt = 0;
      exp_op = 0; exp_a = 0; exp_b = 0;
    end else if (rx_done) begin
      idle_cnt = 0;
      if (frame_len == 0) begin
        if (rx_data == 8'h2B)      begin frame_op = 1; frame_len = 1; end
        else if (rx_data == 8'h2D) begin frame_op = 2; frame_len = 1; end
        else                       exp_err = 1'b1;
      end else if (frame_len == 1) begin
        frame_a   = int'(rx_data) & MASK;
        frame_len = 2;
      end else begin
        exp_op    = frame_op;
        exp_a     = frame_a;
        exp_b     = int'(rx_data) & MASK;
        exp_valid = 1'b1;
        frame_len = 0;
      end
    end else if (frame_len != 0 && TO_EN) begin
      idle_cnt++;
      if (idle_cnt >= TIMEOUT) begin
        exp_err   = 1'b1;
        frame_len = 0;
        idle_cnt  = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("err", 32'(err), 32'(exp_err));
      check("op_out", 32'(op_out), 32'(exp_op));
      check("a_out", 32'(a_out), 32'(exp_a));
      check("b_out", 32'(b_out), 32'(exp_b));
      check("valid_err_excl", 32'(out_valid & err), 32'd0);
      if (out_valid) check("op_not_nop", 32'(op_out != NOP), 32'd1);
    end
  end

  // Tasks start and end on a falling edge, so back-to-back calls give
  // consecutive byte strobes.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] pick_byte();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 4) return 8'h2B;
    if (r < 7) return 8'h2D;
    return 8'($urandom_range(0, 255));
  endfunction

  int err_seen;

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_op", 32'(op_out), 32'd0);
    check("reset_a", 32'(a_out), 32'd0);
    check("reset_b", 32'(b_out), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);

    // Basic add command.
    send(8'h2B); send(8'h05); send(8'h03);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_op", 32'(op_out), 32'd1);
    check("add_a", 32'(a_out), 32'd5);
    check("add_b", 32'(b_out), 32'd3);
    check("add_err", 32'(err), 32'd0);
    idle(2);

    // Bad opcode, then a sub command.
    send(8'h41);
    check("badop_err", 32'(err), 32'd1);
    check("badop_valid", 32'(out_valid), 32'd0);
    send(8'h2D); send(8'h3F); send(8'h01);
    check("sub_valid", 32'(out_valid), 32'd1);
    check("sub_op", 32'(op_out), 32'd2);
    check("sub_a", 32'(a_out), 32'd63);
    check("sub_b", 32'(b_out), 32'd1);
    idle(1);

    // Upper operand bits are dropped.
    send(8'h2B); send(8'hC7); send(8'hFF);
    check("trunc_a", 32'(a_out), 32'h07);
    check("trunc_b", 32'(b_out), 32'h3F);
    check("trunc_err", 32'(err), 32'd0);
    idle(1);

    // Reset mid-frame discards it; outputs sit at reset values until the next frame.
    send(8'h2B); send(8'h01);
    pulse_rst();
    check("rst_op", 32'(op_out), 32'd0);
    check("rst_a", 32'(a_out), 32'd0);
    send(8'h2D); send(8'h02);
    check("rst_hold_op", 32'(op_out), 32'd0);
    check("rst_hold_b", 32'(b_out), 32'd0);
    send(8'h02);
    check("rst_sub_op", 32'(op_out), 32'd2);
    check("rst_sub_a", 32'(a_out), 32'd2);
    check("rst_sub_b", 32'(b_out), 32'd2);
    idle(1);

    // Back-to-back frames: next opcode arrives during the out_valid cycle.
    send(8'h2B); send(8'h11); send(8'h22);
    check("b2b1_valid", 32'(out_valid), 32'd1);
    check("b2b1_a", 32'(a_out), 32'h11);
    send(8'h2D); send(8'h33); send(8'h0A);
    check("b2b2_valid", 32'(out_valid), 32'd1);
    check("b2b2_op", 32'(op_out), 32'd2);
    check("b2b2_a", 32'(a_out), 32'h33);
    check("b2b2_b", 32'(b_out), 32'h0A);
    idle(1);

    // Long silence after an opcode.
    send(8'h2B);
    err_seen = 0;
    for (int i = 0; i < 20; i++) begin
      err_seen += int'(err);
      @(negedge clk);
    end
`ifdef UART_CMD_TIMEOUT_EN
    check("timeout_err_count", 32'(err_seen), 32'd1);
    send(8'h2B); send(8'h04); send(8'h04);
`else
    check("no_timeout_err_count", 32'(err_seen), 32'd0);
    send(8'h04); send(8'h04);
`endif
    check("after_gap_valid", 32'(out_valid), 32'd1);
    check("after_gap_op", 32'(op_out), 32'd1);
    check("after_gap_a", 32'(a_out), 32'd4);
    check("after_gap_b", 32'(b_out), 32'd4);
    idle(1);

    // Randomized byte stream with occasional resets and long gaps.
    for (int i = 0; i < 4000; i++) begin
      if ((i % 300) == 150) begin
        idle(int'($urandom_range(10, 24)));
      end
      rst     = ($urandom_range(0, 99) < 2);
      rx_done = ($urandom_range(0, 99) < 55);
      rx_data = pick_byte();
      @(negedge clk);
    end
    rst = 1'b0;
    rx_done = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter WIDTH, default 6, operand width in bits; legal range 1..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, inter-byte timeout in clk cycles; legal range 2..2^24-1.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rx_data  input  8  received byte from the UART receiver; valid only when rx_done=1.
REQ-006 rx_done  input  1  one-cycle strobe: rx_data holds a new byte.
REQ-007 op_out  output  operation_t  decoded operation for the ALU.
REQ-008 a_out  output  WIDTH  operand A for the ALU.
REQ-009 b_out  output  WIDTH  operand B for the ALU.
REQ-010 out_valid  output  1  one-cycle strobe: op_out/a_out/b_out form a complete command.
REQ-011 err  output  1  one-cycle strobe: frame rejected (bad opcode or timeout).

Function
REQ-012 Frame = 3 bytes in order: opcode, A, B; parser SHALL be a 3-state FSM: IDLE, GET_A, GET_B.
REQ-013 IDLE + rx_done: opcode byte 0x2B ('+') -> capture add, go GET_A; 0x2D ('-') -> capture sub, go GET_A; any other byte -> err=1 for the next cycle, stay IDLE.
REQ-014 GET_A + rx_done: capture rx_data[WIDTH-1:0] as A, go GET_B; upper bits discarded silently.
REQ-015 GET_B + rx_done: capture rx_data[WIDTH-1:0] as B, go IDLE; out_valid=1 on the next cycle (registered, latency 1 clk after the B strobe).
REQ-016 op_out/a_out/b_out SHALL update only when out_valid is asserted and hold their values until the next complete frame; partial frames never disturb them.
REQ-017 out_valid and err SHALL never both be 1 in the same cycle and each SHALL last exactly one cycle.
REQ-018 An rx_done in the same cycle as out_valid is legal; it is processed as an opcode byte in IDLE.
REQ-019 Cycles with rx_done=0 SHALL leave the FSM state unchanged, except through timeout (REQ-024).
REQ-020 op_out SHALL never present nop together with out_valid=1.

Reset
REQ-021 With rst=1 at a clock edge: state=IDLE, op_out=nop, a_out=0, b_out=0, out_valid=0, err=0, timeout counter=0.
REQ-022 Reset mid-frame SHALL discard the partial frame with no out_valid and no err; rx_done during reset is ignored.

Configuration
REQ-023 Macro UART_CMD_TIMEOUT_EN selects the inter-byte timeout.
REQ-024 Defined: a counter SHALL clear on every rx_done and increment each cycle in GET_A/GET_B; when it reaches TIMEOUT_CYCLES-1 the FSM SHALL return to IDLE with err=1 for one cycle; if rx_done coincides with the timeout cycle, rx_done wins and no err is raised.
REQ-025 Not defined: no counter hardware; the FSM waits indefinitely in GET_A/GET_B.

Structure
REQ-026 operation_t (nop=0, add=1, sub=2) and the opcode byte constants 0x2B/0x2D SHALL reside in shared package alu_pkg, also used by the ALU.
REQ-027 The design SHALL be a single flat module; no sub-module is required.
REQ-028 out_valid/op_out/a_out/b_out SHALL connect directly to ALU in_valid/op_in/a_in/b_in.

Verification
REQ-029 Bytes 0x2B,0x05,0x03 (WIDTH=6) -> one out_valid pulse, op_out=add, a_out=5, b_out=3, err=0.
REQ-030 Bytes 0x41 then 0x2D,0x3F,0x01 -> err pulse after 0x41, then out_valid with op_out=sub, a_out=63, b_out=1.
REQ-031 Bytes 0x2B,0xC7,0xFF (WIDTH=6) -> a_out=0x07, b_out=0x3F; no err.
REQ-032 0x2B,0x01, rst pulsed, then 0x2D,0x02,0x02 -> no output from the first frame; out_valid with sub,2,2; outputs held the reset values until then.
REQ-033 UART_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16: 0x2B then 20 idle cycles -> err exactly once, FSM back in IDLE; 0x2B,0x04,0x04 then completes normally.
REQ-034 Back-to-back frames with the next opcode strobed in the out_valid cycle -> both commands emitted, no byte lost.
